// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state type and width helpers for the conv3d fold kernel
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_RND,
        ST_OUT
    } state_t;

    // Wide enough for the full K-term dot product plus bias with one bit of headroom.
    function automatic int acc_width(input int kern_width, input int din_width,
                                     input int k, input int bias_width);
        int prod_sum;
        prod_sum = kern_width + din_width + $clog2(k) + 1;
        return ((prod_sum > bias_width) ? prod_sum : bias_width) + 1;
    endfunction

    function automatic int nbeats(input int k, input int par);
        return (k + par - 1) / par;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv3d_fold_kernel_if.sv
// rtl/conv3d_fold_kernel_if.sv - input window and output result handshakes
interface conv3d_fold_kernel_if
    import conv_pkg::*;
#(
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 8,
    parameter int KERN_L     = 3,
    parameter int KERN_H     = 3,
    parameter int KERN_W     = 3,
    parameter int N_OUT      = 4
);
    localparam int CW = min1_clog2(N_OUT);

    logic                                                     din_vld;
    logic                                                     din_rdy;
    logic signed [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0] din;
    logic                                                     dout_vld;
    logic                                                     dout_rdy;
    logic signed [DOUT_WIDTH-1:0]                             dout;
    logic [CW-1:0]                                            dout_ch;
    logic                                                     dout_last;

    modport master (
        output din_vld, din, dout_rdy,
        input  din_rdy, dout_vld, dout, dout_ch, dout_last
    );

    modport slave (
        input  din_vld, din, dout_rdy,
        output din_rdy, dout_vld, dout, dout_ch, dout_last
    );

endinterface

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - round-half-up shift, saturation and optional ReLU
module conv_requant #(
    parameter int ACC_WIDTH   = 31,
    parameter int DOUT_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    input  logic                         relu_en,
    output logic signed [DOUT_WIDTH-1:0] result
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int XW = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] MAX_V = XW'(2 ** (DOUT_WIDTH - 1) - 1);
    localparam logic signed [XW-1:0] MIN_V = XW'(-(2 ** (DOUT_WIDTH - 1)));

    logic [XW-1:0]        half;
    logic signed [XW-1:0] rounded;

    // Round, shift, clamp to the output range, then drop negatives when ReLU is on
    always_comb begin
        half    = '0;
        rounded = XW'(acc);
        if (shift != '0) begin
            half    = XW'(1) << (shift - SHIFT_WIDTH'(1));
            rounded = (XW'(acc) + $signed(half)) >>> shift;
        end
        if (rounded > MAX_V) begin
            result = DOUT_WIDTH'(MAX_V);
        end else if (rounded < MIN_V) begin
            result = DOUT_WIDTH'(MIN_V);
        end else begin
            result = DOUT_WIDTH'(rounded);
        end
        if (relu_en && result < 0) begin
            result = '0;
        end
    end

endmodule

// File: rtl/conv3d_fold_kernel.sv
// rtl/conv3d_fold_kernel.sv - folded 3-D convolution window over N_OUT kernel sets
module conv3d_fold_kernel
    import conv_pkg::*;
#(
    parameter int KERN_WIDTH  = 16,
    parameter int DIN_WIDTH   = 8,
    parameter int DOUT_WIDTH  = 8,
    parameter int BIAS_WIDTH  = 24,
    parameter int KERN_L      = 3,
    parameter int KERN_H      = 3,
    parameter int KERN_W      = 3,
    parameter int N_OUT       = 4,
    parameter int PAR         = 9,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [N_OUT-1:0][KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][KERN_WIDTH-1:0] kernel,
    input  logic signed [N_OUT-1:0][BIAS_WIDTH-1:0] bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                 relu_en,
    conv3d_fold_kernel_if.slave  bus
);
    localparam int K   = KERN_L * KERN_H * KERN_W;
    localparam int NB  = nbeats(K, PAR);
    localparam int AW  = acc_width(KERN_WIDTH, DIN_WIDTH, K, BIAS_WIDTH);
    localparam int PW  = KERN_WIDTH + DIN_WIDTH;
    localparam int CW  = min1_clog2(N_OUT);
    localparam int BTW = min1_clog2(NB);
    localparam logic [CW-1:0]  LAST_CH   = CW'(N_OUT - 1);
    localparam logic [BTW-1:0] LAST_BEAT = BTW'(NB - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [CW-1:0]                 ch;
    logic [BTW-1:0]                beat;
    logic signed [AW-1:0]          acc;
    logic [K*DIN_WIDTH-1:0]        win;
    logic signed [DOUT_WIDTH-1:0]  dout_q;
    logic signed [DOUT_WIDTH-1:0]  rq;

    // Window and coefficients zero-padded to whole beats, so lanes past K multiply by zero.
    logic [NB-1:0][PAR*DIN_WIDTH-1:0]  win_pad;
    logic [NB-1:0][PAR*KERN_WIDTH-1:0] coef_pad;
    logic [PAR*DIN_WIDTH-1:0]          win_beat;
    logic [PAR*KERN_WIDTH-1:0]         coef_beat;
    logic signed [PW-1:0]              prod;
    logic signed [AW-1:0]              psum;

    assign win_pad   = (NB * PAR * DIN_WIDTH)'(win);
    assign coef_pad  = (NB * PAR * KERN_WIDTH)'(kernel[ch]);
    assign win_beat  = win_pad[beat];
    assign coef_beat = coef_pad[beat];

    // Sum of the PAR lane products for the current beat of the current channel
    always_comb begin
        psum = '0;
        prod = '0;
        for (int lane = 0; lane < PAR; lane++) begin
            prod = PW'($signed(win_beat[lane*DIN_WIDTH +: DIN_WIDTH]))
                 * PW'($signed(coef_beat[lane*KERN_WIDTH +: KERN_WIDTH]));
            psum = psum + AW'(prod);
        end
    end

    conv_requant #(
        .ACC_WIDTH  (AW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_requant (
        .acc    (acc),
        .shift  (shift),
        .relu_en(relu_en),
        .result (rq)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept a window, fold NB beats per channel, requantise, hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.din_vld) state_nxt = ST_MAC;
            ST_MAC:  if (beat == LAST_BEAT) state_nxt = ST_RND;
            ST_RND:  state_nxt = ST_OUT;
            ST_OUT:  if (bus.dout_rdy) state_nxt = (ch == LAST_CH) ? ST_IDLE : ST_MAC;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Window latch, channel/beat counters, accumulator and registered result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win    <= '0;
            ch     <= '0;
            beat   <= '0;
            acc    <= '0;
            dout_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.din_vld) begin
                        win  <= bus.din;
                        ch   <= '0;
                        beat <= '0;
                        acc  <= AW'($signed(bias[0]));
                    end
                end
                ST_MAC: begin
                    acc <= acc + psum;
                    if (beat != LAST_BEAT) beat <= beat + BTW'(1);
                end
                ST_RND: dout_q <= rq;
                ST_OUT: begin
                    if (bus.dout_rdy && ch != LAST_CH) begin
                        ch   <= ch + CW'(1);
                        beat <= '0;
                        acc  <= AW'($signed(bias[ch + CW'(1)]));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.din_rdy   = (state == ST_IDLE);
    assign bus.dout_vld  = (state == ST_OUT);
    assign bus.dout      = dout_q;
    assign bus.dout_ch   = ch;
    assign bus.dout_last = (state == ST_OUT) && (ch == LAST_CH);

endmodule

// File: tb/tb_conv3d_fold_kernel.sv
// tb/tb_conv3d_fold_kernel.sv - bench for conv3d_fold_kernel
module tb_conv3d_fold_kernel;
    localparam int K  = 27;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    conv3d_fold_kernel_if #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .KERN_L(3), .KERN_H(3), .KERN_W(3), .N_OUT(4)) ia ();
    conv3d_fold_kernel_if #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .KERN_L(3), .KERN_H(3), .KERN_W(3), .N_OUT(4)) ib ();

    logic signed [3:0][2:0][2:0][2:0][15:0] kern_a, kern_b;
    logic signed [3:0][23:0] bias_a, bias_b;
    logic [4:0] shift_a, shift_b;
    logic relu_a, relu_b;

    conv3d_fold_kernel dut_a (
        .clk(clk), .reset_n(rst_n), .kernel(kern_a), .bias(bias_a),
        .shift(shift_a), .relu_en(relu_a), .bus(ia)
    );

    conv3d_fold_kernel #(.PAR(4)) dut_b (
        .clk(clk), .reset_n(rst_n), .kernel(kern_b), .bias(bias_b),
        .shift(shift_b), .relu_en(relu_b), .bus(ib)
    );

    int     din_m [K];
    int     kern_m [NO][K];
    int     bias_m [NO];
    int     sh_m;
    bit     relu_m;
    longint exp_m [NO];

    typedef struct packed {
        int   d0;
        int   dr;
        int   kv;
        int   bv;
        int   sh;
        logic relu;
        int   ev;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int id, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s id=%0d act=%0d exp=%0d", name, id, act, expv);
        end
    endtask

    // Dot product over the whole window, then round/saturate/relu with plain integers.
    function automatic longint model(input int c);
        longint a;
        a = bias_m[c];
        for (int i = 0; i < K; i++) a += longint'(din_m[i]) * longint'(kern_m[c][i]);
        if (sh_m > 0) a = (a + (longint'(1) << (sh_m - 1))) >>> sh_m;
        if (a > 127) a = 127;
        if (a < -128) a = -128;
        if (relu_m && a < 0) a = 0;
        return a;
    endfunction

    task automatic pack_a();
        for (int c = 0; c < NO; c++) begin
            bias_a[c] = 24'(bias_m[c]);
            for (int l = 0; l < 3; l++)
                for (int h = 0; h < 3; h++)
                    for (int w = 0; w < 3; w++)
                        kern_a[c][l][h][w] = 16'(kern_m[c][(l*3+h)*3+w]);
        end
        for (int l = 0; l < 3; l++)
            for (int h = 0; h < 3; h++)
                for (int w = 0; w < 3; w++)
                    ia.din[l][h][w] = 8'(din_m[(l*3+h)*3+w]);
        shift_a = 5'(sh_m);
        relu_a  = relu_m;
    endtask

    task automatic run_window(input int id, input int stall_ch, input int stall_n);
        int cnt;
        pack_a();
        cnt = 0;
        while (ia.din_rdy !== 1'b1 && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("din_rdy_idle", id, ia.din_rdy, 1);
        ia.din_vld = 1'b1;
        @(posedge clk); #1;
        ia.din_vld = 1'b0;
        chk("din_rdy_busy", id, ia.din_rdy, 0);
        for (int c = 0; c < NO; c++) begin
            cnt = 1;
            while (ia.dout_vld !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
            chk("latency", id, cnt, 5);
            chk("dout", id, ia.dout, exp_m[c]);
            chk("dout_ch", id, ia.dout_ch, c);
            chk("dout_last", id, ia.dout_last, (c == NO - 1) ? 1 : 0);
            if (c == stall_ch) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    chk("stall_vld", id, ia.dout_vld, 1);
                    chk("stall_dout", id, ia.dout, exp_m[c]);
                    chk("stall_ch", id, ia.dout_ch, c);
                    chk("stall_din_rdy", id, ia.din_rdy, 0);
                end
            end
            ia.dout_rdy = 1'b1;
            @(posedge clk); #1;
            ia.dout_rdy = 1'b0;
        end
        chk("din_rdy_done", id, ia.din_rdy, 1);
    endtask

    task automatic randomize_window();
        for (int i = 0; i < K; i++) din_m[i] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < NO; c++) begin
            bias_m[c] = int'($urandom_range(0, 16777215)) - 8388608;
            for (int i = 0; i < K; i++) kern_m[c][i] = int'($urandom_range(0, 65535)) - 32768;
        end
        sh_m   = int'($urandom_range(0, 20));
        relu_m = 1'($urandom_range(0, 1));
        for (int c = 0; c < NO; c++) exp_m[c] = model(c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog id=0 act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;

        ia.din_vld = 1'b0; ia.dout_rdy = 1'b0; ia.din = '0;
        ib.din_vld = 1'b0; ib.dout_rdy = 1'b0; ib.din = '0;
        kern_a = '0; bias_a = '0; shift_a = '0; relu_a = 1'b0;
        kern_b = '0; bias_b = '0; shift_b = '0; relu_b = 1'b0;

        tbl[0]  = '{1,    1,   1,    0,    0, 1'b0,   27};
        tbl[1]  = '{127,  127, 100,  0,    0, 1'b0,  127};
        tbl[2]  = '{127,  127, -100, 0,    0, 1'b0, -128};
        tbl[3]  = '{127,  127, -100, 0,    0, 1'b1,    0};
        tbl[4]  = '{6,    0,   1,    0,    2, 1'b0,    2};
        tbl[5]  = '{-6,   0,   1,    0,    2, 1'b0,   -1};
        tbl[6]  = '{1,    1,   1,    5,    1, 1'b0,   16};
        tbl[7]  = '{5,    0,   1,    0,    1, 1'b0,    3};
        tbl[8]  = '{-5,   0,   1,    0,    1, 1'b0,   -2};
        tbl[9]  = '{1,    1,   1,    -100, 0, 1'b1,    0};
        tbl[10] = '{2,    2,   2,    0,    0, 1'b0,  108};
        tbl[11] = '{1,    1,   1,    100,  0, 1'b0,  127};
        tbl[12] = '{1,    1,   1,    101,  0, 1'b0,  127};
        tbl[13] = '{1,    1,   1,    -155, 0, 1'b0, -128};
        tbl[14] = '{1,    1,   1,    -156, 0, 1'b0, -128};
        tbl[15] = '{1,    1,   1,    -155, 0, 1'b1,    0};
        tbl[16] = '{1,    1,   1,    0,    0, 1'b1,   27};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_din_rdy", 0, ia.din_rdy, 1);
        chk("rst_dout_vld", 0, ia.dout_vld, 0);
        chk("rst_dout", 0, ia.dout, 0);
        chk("rst_dout_ch", 0, ia.dout_ch, 0);
        chk("rst_dout_last", 0, ia.dout_last, 0);
        chk("rst_b_din_rdy", 0, ib.din_rdy, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 17; v++) begin
            din_m[0] = tbl[v].d0;
            for (int i = 1; i < K; i++) din_m[i] = tbl[v].dr;
            for (int c = 0; c < NO; c++) begin
                bias_m[c] = tbl[v].bv;
                exp_m[c]  = tbl[v].ev;
                for (int i = 0; i < K; i++) kern_m[c][i] = tbl[v].kv;
            end
            sh_m   = tbl[v].sh;
            relu_m = tbl[v].relu;
            run_window(v, (v == 0) ? 1 : v % NO, (v == 0) ? 10 : v % 3);
        end

        for (int r = 0; r < 10; r++) begin
            randomize_window();
            run_window(100 + r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of channel 1's accumulation
        for (int i = 0; i < K; i++) din_m[i] = 1;
        for (int c = 0; c < NO; c++) begin
            bias_m[c] = 0;
            for (int i = 0; i < K; i++) kern_m[c][i] = 1;
        end
        sh_m = 0; relu_m = 1'b0;
        pack_a();
        ia.din_vld = 1'b1;
        @(posedge clk); #1;
        ia.din_vld = 1'b0;
        cnt = 1;
        while (ia.dout_vld !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("rst_seq_ch0", 200, ia.dout, 27);
        ia.dout_rdy = 1'b1;
        @(posedge clk); #1;
        ia.dout_rdy = 1'b0;
        @(posedge clk); #1;
        chk("rst_seq_busy", 200, ia.din_rdy, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 200, ia.dout_vld, 0);
        chk("rst_mid_din_rdy", 200, ia.din_rdy, 1);
        chk("rst_mid_ch", 200, ia.dout_ch, 0);
        chk("rst_mid_dout", 200, ia.dout, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ia.dout_vld === 1'b1) seen = 1'b1;
        end
        chk("rst_no_output", 200, seen, 0);
        chk("rst_rel_din_rdy", 200, ia.din_rdy, 1);
        randomize_window();
        run_window(201, 0, 0);

        // PAR=4: seven beats with a zero-padded final beat
        for (int c = 0; c < NO; c++) begin
            bias_b[c] = (c == 2) ? -24'sd5 : 24'sd0;
            for (int l = 0; l < 3; l++)
                for (int h = 0; h < 3; h++)
                    for (int w = 0; w < 3; w++)
                        kern_b[c][l][h][w] = 16'sd1;
        end
        for (int l = 0; l < 3; l++)
            for (int h = 0; h < 3; h++)
                for (int w = 0; w < 3; w++)
                    ib.din[l][h][w] = 8'sd1;
        chk("b_din_rdy", 300, ib.din_rdy, 1);
        ib.din_vld = 1'b1;
        @(posedge clk); #1;
        ib.din_vld = 1'b0;
        for (int c = 0; c < NO; c++) begin
            cnt = 1;
            while (ib.dout_vld !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
            chk("b_latency", 300 + c, cnt, 9);
            chk("b_dout", 300 + c, ib.dout, (c == 2) ? 22 : 27);
            chk("b_dout_last", 300 + c, ib.dout_last, (c == 3) ? 1 : 0);
            ib.dout_rdy = 1'b1;
            @(posedge clk); #1;
            ib.dout_rdy = 1'b0;
        end
        chk("b_din_rdy_done", 300, ib.din_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv3d_fold_kernel.md
CONV3D_FOLD_KERNEL -- requirements
Module: conv3d_fold_kernel

Interface
REQ-001 SHALL have parameter KERN_WIDTH, default 16, signed kernel coefficient width.
REQ-002 SHALL have parameter DIN_WIDTH, default 8, signed input sample width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 8, signed output width.
REQ-004 SHALL have parameter BIAS_WIDTH, default 24, signed per-channel bias width.
REQ-005 SHALL have parameters KERN_L, KERN_H, KERN_W, default 3 each, window dimensions; K = KERN_L*KERN_H*KERN_W.
REQ-006 SHALL have parameter N_OUT, default 4, number of output channels (kernel sets).
REQ-007 SHALL have parameter PAR, default 9, multipliers used per cycle; NBEATS = ceil(K/PAR).
REQ-008 SHALL have parameter SHIFT_WIDTH, default 5, width of requantisation shift.
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 kernel  in  signed [N_OUT][KERN_L][KERN_H][KERN_W][KERN_WIDTH]  coefficient sets; static while busy.
REQ-012 bias  in  signed [N_OUT][BIAS_WIDTH]  per-channel bias; static while busy.
REQ-013 shift  in  SHIFT_WIDTH  arithmetic right shift applied before saturation; static while busy.
REQ-014 relu_en  in  1  clamp negative results to zero; static while busy.
REQ-015 din_vld / din_rdy  in / out  1  input window handshake.
REQ-016 din  in  signed [KERN_L][KERN_H][KERN_W][DIN_WIDTH]  input window.
REQ-017 dout_vld / dout_rdy  out / in  1  output handshake.
REQ-018 dout  out  signed [DOUT_WIDTH]  requantised result; dout_ch  out  $clog2(N_OUT) (min 1)  channel index; dout_last  out  1  high on channel N_OUT-1.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, RND, OUT.
REQ-020 din_rdy SHALL equal (state==IDLE); transfer occurs when din_vld&&din_rdy; accepted window SHALL be latched internally.
REQ-021 On transfer: channel counter:=0, beat counter:=0, accumulator:=sign-extended bias[0], state:=MAC.
REQ-022 Each MAC cycle SHALL add the sum of PAR products din[i]*kernel[ch][i], i = beat*PAR+lane, flat index L-major then H then W; lanes with i>=K contribute zero.
REQ-023 Accumulator width SHALL be max(KERN_WIDTH+DIN_WIDTH+$clog2(K)+1, BIAS_WIDTH)+1; no internal overflow.
REQ-024 After beat NBEATS-1, state:=RND; RND SHALL register dout = requant(acc) and go to OUT.
REQ-025 requant: if shift>0, r = (acc + 2^(shift-1)) >>> shift, else r = acc; saturate r to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; if relu_en and r<0, r=0.
REQ-026 dout_vld SHALL equal (state==OUT); dout, dout_ch, dout_last SHALL stay stable while dout_vld&&!dout_rdy.
REQ-027 On dout_vld&&dout_rdy: if ch<N_OUT-1, ch:=ch+1, acc:=bias[ch+1], beat:=0, state:=MAC; else state:=IDLE.
REQ-028 Latency from input transfer to first dout_vld SHALL be NBEATS+2 cycles; each further channel NBEATS+2 cycles after the previous output transfer.
REQ-029 din_rdy SHALL be low from the transfer cycle until the last channel's output transfer completes; new window accepted no earlier than the cycle after.
REQ-030 N_OUT=1 SHALL return to IDLE after one output; PAR>=K SHALL give NBEATS=1.

Reset
REQ-031 Asserting reset_n low SHALL immediately force state IDLE, counters 0, accumulator 0, dout 0, dout_vld 0, dout_ch 0, dout_last 0; din_rdy SHALL be 1 after reset.
REQ-032 Reset during MAC/RND/OUT SHALL discard the in-flight window; no output for it after release.

Structure
REQ-033 Shared package conv_pkg SHALL hold the FSM state enum and width helper functions (accumulator width, NBEATS).
REQ-034 Requantisation (REQ-025) SHALL be a combinational sub-module conv_requant.

Verification
REQ-035 K=27, PAR=9, din all 1, kernel all 1, bias 0, shift 0 -> dout=27 on channels 0..3, first dout_vld 5 cycles after transfer.
REQ-036 din all 127, kernel all 100, shift 0 -> dout=127 (saturated); kernel all -100, relu_en 0 -> -128; relu_en 1 -> 0.
REQ-037 Rounding: single nonzero product 6, shift 2 -> dout=2; product -6, shift 2 -> dout=-1.
REQ-038 dout_rdy low 10 cycles during OUT -> dout/dout_ch stable, din_rdy 0; dout_last only on channel 3.
REQ-039 reset_n low mid-MAC of channel 1 -> dout_vld 0 immediately, din_rdy 1 after release, next window yields correct channel 0 result.
REQ-040 PAR=4 (NBEATS=7, zero-padded last beat), bias[2]=-5, all-ones data -> channel 2 dout=22, latency 9 cycles.
